ppu_nt_ram: RTL and testbench
=============================

Name: ppu_nt_ram

Overview:
- Parametrised successor to the fixed 2KB PPU nametable VRAM plus its separate mirroring decode.
- One dual-port synchronous RAM with built-in nametable mirroring (five modes), registered reads, and defined write-collision and read-during-write rules.
- Includes a fill sequencer that sweeps the whole array after reset or on request.
- Sits between the PPU fetch pipeline (port A) and the CPU-side PPUDATA path (port B).

Parameters:
- ADDR_W, 11: physical RAM address width. 11 = 2KB; 12 = 4KB, which is needed for four-screen mode.
- DATA_W, 8: word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- clk_en  in  1  PPU clock enable (master/4). All state advances only when high.
- mirroring  in  3  mirroring mode: 0 VER, 1 HOR, 2 SINGLE_A, 3 SINGLE_B, 4 FOUR. Codes 5-7 behave as SINGLE_A.
- clear_req  in  1  request a full-array fill.
- fill_val  in  DATA_W  fill value for a requested clear.
- busy  out  1  fill sequencer active.
- a_addr  in  16  PPU address, port A.
- a_we  in  1  write enable, port A.
- a_wdata  in  DATA_W  write data, port A.
- a_rdata  out  DATA_W  registered read data, port A.
- b_addr, b_we, b_wdata, b_rdata: same as port A, for port B.

Behaviour:
- Address map (combinational, per port). t = addr[11:10]; bits 15:12 are ignored, so 0x3000-0x3EFF mirrors 0x2000-0x2EFF.
  - VER: phys = {t[0], addr[9:0]}.
  - HOR: phys = {t[1], addr[9:0]}.
  - SINGLE_A: phys = {0, addr[9:0]}.
  - SINGLE_B: phys = {1, addr[9:0]}.
  - FOUR: phys = {t, addr[9:0]} when ADDR_W >= 12; when ADDR_W = 11, FOUR behaves as VER.
  - phys is zero-extended to ADDR_W.
  - A change on mirroring takes effect on the next access; stored data is never moved.
- Read latency: one enabled cycle. On each clk edge with clk_en = 1 and busy = 0, x_rdata <= word at phys(x_addr). With clk_en = 0, rdata holds.
- Read-during-write is write-first:
  - same port writing the same phys: rdata = new data;
  - other port writing the same phys in the same cycle: rdata = the winning new data.
- Simultaneous writes to the same phys: port A wins; port B's write is dropped.
- Writes to different phys addresses in the same cycle both commit.
- Writes commit only when clk_en = 1 and busy = 0.
- Fill FSM, states IDLE and FILL:
  - rst (any state, including mid-FILL) -> FILL with cnt = 0 and fill value 0.
  - IDLE + clear_req + clk_en -> FILL with cnt = 0; fill_val is latched in that cycle.
  - In FILL, each enabled cycle writes the latched value to mem[cnt] and increments cnt.
  - When cnt = 2**ADDR_W - 1 has been written, go to IDLE.
  - A full fill takes exactly 2**ADDR_W enabled cycles.
  - clear_req while in FILL is ignored.
  - During FILL, port writes are dropped and a_rdata/b_rdata hold their values.
- busy = 1 exactly when the state is FILL. Port accesses resume in the first enabled cycle after busy falls.
- Reset values: a_rdata = 0, b_rdata = 0, busy = 1, cnt = 0, state = FILL.

Test Plan:
- Reset fill: ADDR_W = 11, clk_en every 4th clk, pulse rst.
  - busy = 1 for exactly 2048 enabled cycles (8192 clk), then 0.
  - A read of 0x27FF after busy falls returns 0x00.
- VER mirroring: write 0xAB to A:0x2000.
  - B read 0x2800 -> 0xAB one enabled cycle later.
  - B read 0x2400 -> 0x00.
  - Switch to HOR: B read 0x2400 -> 0xAB.
- Collision: A and B both write 0x2123 (A = 0x11, B = 0x22) in the same cycle.
  - Next cycle, both read 0x2123 -> 0x11 on a_rdata and b_rdata.
- Cross-port read-during-write: A writes 0x5C to 0x3C10 while B reads 0x2C10 in the same cycle (HOR mode).
  - b_rdata = 0x5C next enabled cycle.
- Clear with abort:
  - clear_req with fill_val = 0xFF; assert rst after 100 enabled cycles.
  - busy stays 1, the fill restarts from 0 with value 0x00, and any read after completion -> 0x00.
  - Then clear_req with 0xFF to completion: reads of 0x2000 and 0x2FFF -> 0xFF.
  - A port write issued during busy is not stored.
- FOUR mode, ADDR_W = 12: write 0x2000 = 0x01, 0x2400 = 0x02, 0x2800 = 0x03, 0x2C00 = 0x04.
  - Read-back is distinct per table (0x01, 0x02, 0x03, 0x04).
  - With ADDR_W = 11, the same sequence reads 0x03, 0x04, 0x03, 0x04.

Source files
------------

// File: rtl/ppu_nt_ram_if.sv
// Bus bundle for the PPU nametable RAM: two access ports plus the mirroring
// and fill-control sideband, shared by the RAM and whoever drives it.
interface ppu_nt_ram_if #(
   parameter int DATA_W = 8
);
   logic              clk_en;
   logic [2:0]        mirroring;
   logic              clear_req;
   logic [DATA_W-1:0] fill_val;
   logic              busy;

   logic [15:0]       a_addr;
   logic              a_we;
   logic [DATA_W-1:0] a_wdata;
   logic [DATA_W-1:0] a_rdata;

   logic [15:0]       b_addr;
   logic              b_we;
   logic [DATA_W-1:0] b_wdata;
   logic [DATA_W-1:0] b_rdata;

   modport master (
      output clk_en, mirroring, clear_req, fill_val,
      output a_addr, a_we, a_wdata,
      output b_addr, b_we, b_wdata,
      input  busy, a_rdata, b_rdata
   );

   modport slave (
      input  clk_en, mirroring, clear_req, fill_val,
      input  a_addr, a_we, a_wdata,
      input  b_addr, b_we, b_wdata,
      output busy, a_rdata, b_rdata
   );
endinterface

// File: rtl/ppu_nt_ram.sv
// Dual-port nametable RAM with built-in mirroring decode, write-first reads,
// port-A-wins collisions and a fill sequencer that sweeps the array.
module ppu_nt_ram #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   ppu_nt_ram_if.slave bus
);
   localparam int DEPTH   = 2 ** ADDR_W;
   localparam bit FOUR_OK = (ADDR_W >= 12);

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] fill_q, fill_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] a_phys, b_phys;
   logic              busy, port_en, fill_we, same_phys, a_wr, b_wr;
   logic [DATA_W-1:0] a_fwd, b_fwd;
   logic              unused_bits;

   // Without four-screen storage, FOUR falls back to vertical arrangement.
   function automatic logic [ADDR_W-1:0] map_addr(input logic [11:0] addr,
                                                  input logic [2:0]  mode);
      logic [11:0] p;
      case (mode)
         3'd0:    p = {1'b0, addr[10], addr[9:0]};
         3'd1:    p = {1'b0, addr[11], addr[9:0]};
         3'd3:    p = {2'b01, addr[9:0]};
         3'd4:    p = FOUR_OK ? addr[11:0] : {1'b0, addr[10], addr[9:0]};
         default: p = {2'b00, addr[9:0]};
      endcase
      return ADDR_W'(p);
   endfunction

   assign a_phys      = map_addr(bus.a_addr[11:0], bus.mirroring);
   assign b_phys      = map_addr(bus.b_addr[11:0], bus.mirroring);
   assign unused_bits = ^{bus.a_addr[15:12], bus.b_addr[15:12]};

   assign busy      = (state_q == FILL);
   assign bus.busy  = busy;
   assign port_en   = bus.clk_en && !busy && !rst;
   assign fill_we   = bus.clk_en && busy && !rst;
   assign same_phys = (a_phys == b_phys);
   assign a_wr      = port_en && bus.a_we;
   assign b_wr      = port_en && bus.b_we && !(bus.a_we && same_phys);

   always_comb begin
      a_fwd = mem[a_phys];
      b_fwd = mem[b_phys];
      if (bus.a_we)
         a_fwd = bus.a_wdata;
      else if (bus.b_we && same_phys)
         a_fwd = bus.b_wdata;
      if (bus.a_we && same_phys)
         b_fwd = bus.a_wdata;
      else if (bus.b_we)
         b_fwd = bus.b_wdata;
   end

   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[cnt_q] <= fill_q;
      end else begin
         if (b_wr)
            mem[b_phys] <= bus.b_wdata;
         if (a_wr)
            mem[a_phys] <= bus.a_wdata;
      end
   end

   // Read data freezes while filling so the fetch pipeline sees stable values.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.a_rdata <= '0;
         bus.b_rdata <= '0;
      end else if (port_en) begin
         bus.a_rdata <= a_fwd;
         bus.b_rdata <= b_fwd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      if (bus.clk_en) begin
         case (state_q)
            IDLE: begin
               if (bus.clear_req) begin
                  state_d = FILL;
                  cnt_d   = '0;
                  fill_d  = bus.fill_val;
               end
            end
            FILL: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == '1)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ppu_nt_ram.sv
// Scoreboard bench for ppu_nt_ram: a 2KB and a 4KB instance share clock,
// reset and a divide-by-4 clock enable.
module tb_ppu_nt_ram;
   logic clk = 1'b1;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ppu_nt_ram_if #(.DATA_W(8)) i11 ();
   ppu_nt_ram_if #(.DATA_W(8)) i12 ();

   ppu_nt_ram #(.ADDR_W(11), .DATA_W(8)) dut11 (.clk(clk), .rst(rst), .bus(i11.slave));
   ppu_nt_ram #(.ADDR_W(12), .DATA_W(8)) dut12 (.clk(clk), .rst(rst), .bus(i12.slave));

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_val[$];
   int         exp_sel[$];
   string      exp_tag[$];

   logic [1:0] en_div = 2'd3;
   always @(negedge clk) begin
      en_div     = en_div + 2'd1;
      i11.clk_en = (en_div == 2'd0);
      i12.clk_en = (en_div == 2'd0);
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] rd(input int sel);
      case (sel)
         0:       return i11.a_rdata;
         1:       return i11.b_rdata;
         2:       return i12.a_rdata;
         default: return i12.b_rdata;
      endcase
   endfunction

   task automatic en_cycle();
      @(posedge clk);
      while (i11.clk_en !== 1'b1) @(posedge clk);
      #1;
   endtask

   task automatic set_ports(input int dut,
                            input logic [15:0] aa, input logic awe, input logic [7:0] ad,
                            input logic [15:0] ba, input logic bwe, input logic [7:0] bd);
      if (dut == 0) begin
         i11.a_addr = aa; i11.a_we = awe; i11.a_wdata = ad;
         i11.b_addr = ba; i11.b_we = bwe; i11.b_wdata = bd;
      end else begin
         i12.a_addr = aa; i12.a_we = awe; i12.a_wdata = ad;
         i12.b_addr = ba; i12.b_we = bwe; i12.b_wdata = bd;
      end
   endtask

   // One enabled cycle of port traffic; expected read data is queued before
   // the edge and drained against the registered outputs after it.
   task automatic applyStimulus(input int dut, input string tag,
                                input logic [15:0] aa, input logic awe, input logic [7:0] ad,
                                input bit achk, input logic [7:0] aexp,
                                input logic [15:0] ba, input logic bwe, input logic [7:0] bd,
                                input bit bchk, input logic [7:0] bexp);
      if (achk) begin
         exp_val.push_back(aexp); exp_sel.push_back(dut * 2); exp_tag.push_back({tag, "_a"});
      end
      if (bchk) begin
         exp_val.push_back(bexp); exp_sel.push_back(dut * 2 + 1); exp_tag.push_back({tag, "_b"});
      end
      set_ports(dut, aa, awe, ad, ba, bwe, bd);
      en_cycle();
      set_ports(dut, aa, 1'b0, ad, ba, 1'b0, bd);
      while (exp_val.size() > 0)
         checkOutput(exp_tag.pop_front(), rd(exp_sel.pop_front()), exp_val.pop_front());
   endtask

   task automatic wait_fill(input int dut, output int n);
      n = 0;
      do begin
         en_cycle();
         n++;
      end while (((dut == 0) ? i11.busy : i12.busy) && n < 6000);
   endtask

   int         n;
   logic [7:0] hold_a, hold_b;

   initial begin
      i11.mirroring = 3'd0; i11.clear_req = 1'b0; i11.fill_val = 8'h00;
      i12.mirroring = 3'd0; i12.clear_req = 1'b0; i12.fill_val = 8'h00;
      set_ports(0, 16'h2000, 1'b0, 8'h00, 16'h2000, 1'b0, 8'h00);
      set_ports(1, 16'h2000, 1'b0, 8'h00, 16'h2000, 1'b0, 8'h00);

      repeat (3) en_cycle();
      checkOutput("rst_a_rdata", i11.a_rdata, 8'h00);
      checkOutput("rst_b_rdata", i11.b_rdata, 8'h00);
      checkOutput("rst_busy", i11.busy, 1'b1);
      rst = 1'b0;
      wait_fill(0, n);
      checkOutput("reset_fill_len", n, 2048);
      checkOutput("busy_after_fill", i11.busy, 1'b0);
      applyStimulus(0, "post_fill", 16'h27FF, 0, 8'h00, 1, 8'h00, 16'h2000, 0, 8'h00, 1, 8'h00);

      // Vertical, then horizontal view of the same stored byte
      applyStimulus(0, "ver_wr",   16'h2000, 1, 8'hAB, 1, 8'hAB, 16'h2400, 0, 8'h00, 0, 8'h00);
      applyStimulus(0, "ver_rd",   16'h2400, 0, 8'h00, 1, 8'h00, 16'h2800, 0, 8'h00, 1, 8'hAB);
      i11.mirroring = 3'd1;
      applyStimulus(0, "hor_rd",   16'h2C00, 0, 8'h00, 1, 8'h00, 16'h2400, 0, 8'h00, 1, 8'hAB);

      applyStimulus(0, "coll_wr",  16'h2123, 1, 8'h11, 1, 8'h11, 16'h2123, 1, 8'h22, 1, 8'h11);
      applyStimulus(0, "coll_rd",  16'h2123, 0, 8'h00, 1, 8'h11, 16'h2123, 0, 8'h00, 1, 8'h11);
      applyStimulus(0, "xrdw",     16'h3C10, 1, 8'h5C, 1, 8'h5C, 16'h2C10, 0, 8'h00, 1, 8'h5C);
      applyStimulus(0, "dual_wr",  16'h2001, 1, 8'h31, 1, 8'h31, 16'h2002, 1, 8'h32, 1, 8'h32);
      applyStimulus(0, "dual_rd",  16'h2002, 0, 8'h00, 1, 8'h32, 16'h2001, 0, 8'h00, 1, 8'h31);
      i11.mirroring = 3'd3;
      applyStimulus(0, "single_b", 16'h2010, 0, 8'h00, 1, 8'h5C, 16'h2800, 0, 8'h00, 1, 8'h00);
      i11.mirroring = 3'd7;
      applyStimulus(0, "mode7",    16'h2C00, 0, 8'h00, 1, 8'hAB, 16'h2123, 0, 8'h00, 1, 8'h11);

      // Requested clear cut short by reset
      i11.clear_req = 1'b1; i11.fill_val = 8'hFF;
      en_cycle();
      i11.clear_req = 1'b0; i11.fill_val = 8'h00;
      checkOutput("clear_busy", i11.busy, 1'b1);
      hold_a = i11.a_rdata;
      hold_b = i11.b_rdata;
      set_ports(0, 16'h2200, 1'b1, 8'h99, 16'h2300, 1'b0, 8'h00);
      repeat (99) en_cycle();
      set_ports(0, 16'h2200, 1'b0, 8'h99, 16'h2300, 1'b0, 8'h00);
      checkOutput("busy_hold_a", i11.a_rdata, hold_a);
      checkOutput("busy_hold_b", i11.b_rdata, hold_b);
      checkOutput("busy_mid", i11.busy, 1'b1);
      rst = 1'b1;
      en_cycle();
      rst = 1'b0;
      checkOutput("abort_busy", i11.busy, 1'b1);
      checkOutput("abort_a_rdata", i11.a_rdata, 8'h00);
      wait_fill(0, n);
      checkOutput("abort_fill_len", n, 2048);
      applyStimulus(0, "abort_rd", 16'h2000, 0, 8'h00, 1, 8'h00, 16'h2FFF, 0, 8'h00, 1, 8'h00);

      // Full clear; a write and a second request during the sweep are ignored
      i11.clear_req = 1'b1; i11.fill_val = 8'hFF;
      en_cycle();
      i11.clear_req = 1'b0; i11.fill_val = 8'h00;
      n = 0;
      while (i11.busy && n < 6000) begin
         if (n == 0)   set_ports(0, 16'h2200, 1'b1, 8'h99, 16'h2300, 1'b1, 8'h98);
         if (n == 1)   set_ports(0, 16'h2200, 1'b0, 8'h99, 16'h2300, 1'b0, 8'h98);
         if (n == 500) begin i11.clear_req = 1'b1; i11.fill_val = 8'h55; end
         if (n == 501) begin i11.clear_req = 1'b0; i11.fill_val = 8'h00; end
         en_cycle();
         n++;
      end
      checkOutput("clear_fill_len", n, 2048);
      applyStimulus(0, "clear_rd",  16'h2000, 0, 8'h00, 1, 8'hFF, 16'h2FFF, 0, 8'h00, 1, 8'hFF);
      applyStimulus(0, "drop_wr",   16'h2200, 0, 8'h00, 1, 8'hFF, 16'h2300, 0, 8'h00, 1, 8'hFF);

      // Four-screen on both sizes
      wait_fill(1, n);
      checkOutput("busy12_idle", i12.busy, 1'b0);
      i11.mirroring = 3'd4;
      i12.mirroring = 3'd4;
      for (int d = 0; d < 2; d++) begin
         applyStimulus(d, "four_wr0", 16'h2000, 1, 8'h01, 1, 8'h01, 16'h2100, 0, 8'h00, 0, 8'h00);
         applyStimulus(d, "four_wr1", 16'h2400, 1, 8'h02, 1, 8'h02, 16'h2100, 0, 8'h00, 0, 8'h00);
         applyStimulus(d, "four_wr2", 16'h2800, 1, 8'h03, 1, 8'h03, 16'h2100, 0, 8'h00, 0, 8'h00);
         applyStimulus(d, "four_wr3", 16'h2C00, 1, 8'h04, 1, 8'h04, 16'h2100, 0, 8'h00, 0, 8'h00);
      end
      applyStimulus(1, "four12_r01", 16'h2000, 0, 8'h00, 1, 8'h01, 16'h2400, 0, 8'h00, 1, 8'h02);
      applyStimulus(1, "four12_r23", 16'h2800, 0, 8'h00, 1, 8'h03, 16'h3C00, 0, 8'h00, 1, 8'h04);
      applyStimulus(0, "four11_r01", 16'h2000, 0, 8'h00, 1, 8'h03, 16'h2400, 0, 8'h00, 1, 8'h04);
      applyStimulus(0, "four11_r23", 16'h2800, 0, 8'h00, 1, 8'h03, 16'h2C00, 0, 8'h00, 1, 8'h04);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
